// File: rtl/dp_ctrl_if.sv
// Control bundle between the sequencer and the Phase-1 datapath / memory handshake.
// The sequencer uses the master modport and the datapath side uses the slave modport.
interface dp_ctrl_if #(
   parameter int unsigned W_ENABLE = 32
);
   logic                run;
   logic                mem_rdy;
   logic [31:0]         ir;
   logic [W_ENABLE-1:0] enable;
   logic [4:0]          busSelect;
   logic                MR_Read;
   logic                inc_pc;
   logic [3:0]          Control_Signals;
   logic                busy;
   logic                illegal;

   modport master (
      input  run, mem_rdy, ir,
      output enable, busSelect, MR_Read, inc_pc, Control_Signals, busy, illegal
   );

   modport slave (
      output run, mem_rdy, ir,
      input  enable, busSelect, MR_Read, inc_pc, Control_Signals, busy, illegal
   );
endinterface

// File: rtl/dp_control_sequencer.sv
// Moore sequencer stepping the datapath through fetch (T0-T2) and reg-reg ALU execute (T3-T5).
// Outputs decode from the present state and the live IR only; there is no private IR copy.
module dp_control_sequencer #(
   parameter int unsigned W_ENABLE = 32
) (
   input logic       clk,
   input logic       clr,
   dp_ctrl_if.master bus
);
   localparam int unsigned W_SEL = 5;
   localparam int unsigned W_OP  = 5;
   localparam int unsigned W_REG = 4;
   localparam int unsigned W_ALU = 4;

   localparam logic [W_SEL-1:0] SEL_NONE = W_SEL'(31);
   localparam logic [W_SEL-1:0] SEL_ZLO  = W_SEL'(19);
   localparam logic [W_SEL-1:0] SEL_PC   = W_SEL'(20);
   localparam logic [W_SEL-1:0] SEL_MDR  = W_SEL'(21);

   localparam int unsigned EN_PC  = 20;
   localparam int unsigned EN_MDR = 21;
   localparam int unsigned EN_IR  = 23;
   localparam int unsigned EN_Z   = 24;
   localparam int unsigned EN_MAR = 25;
   localparam int unsigned EN_Y   = 27;

   typedef enum logic [2:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_ILL
   } state_t;

   state_t state, state_nx;

   logic [W_OP-1:0]     opcode;
   logic [W_REG-1:0]    ra, rb, rc;
   logic                legal;
   logic [W_ALU-1:0]    alu_op;
   logic                ir_unused;

   logic [W_ENABLE-1:0] enable_c;
   logic [W_SEL-1:0]    sel_c;
   logic                mr_read_c;
   logic                inc_pc_c;
   logic [W_ALU-1:0]    alu_c;
   logic                busy_c;
   logic                illegal_c;

   assign opcode    = bus.ir[31:27];
   assign ra        = bus.ir[26:23];
   assign rb        = bus.ir[22:19];
   assign rc        = bus.ir[18:15];
   assign ir_unused = ^bus.ir[14:0];

   // Opcode to ALU operation; anything not listed traps.
   always_comb begin
      legal  = 1'b1;
      alu_op = '0;
      case (opcode)
         5'b00011: alu_op = W_ALU'(1);
         5'b00100: alu_op = W_ALU'(2);
         5'b00101: alu_op = W_ALU'(3);
         5'b00110: alu_op = W_ALU'(4);
         default:  legal  = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next state and per-state control outputs.
   always_comb begin
      state_nx  = state;
      enable_c  = '0;
      sel_c     = SEL_NONE;
      mr_read_c = 1'b0;
      inc_pc_c  = 1'b0;
      alu_c     = '0;
      busy_c    = 1'b0;
      illegal_c = 1'b0;
      case (state)
         S_IDLE: if (bus.run) state_nx = S_T0;
         S_T0: begin
            busy_c           = 1'b1;
            sel_c            = SEL_PC;
            enable_c[EN_MAR] = 1'b1;
            enable_c[EN_PC]  = 1'b1;
            inc_pc_c         = 1'b1;
            state_nx         = S_T1;
         end
         S_T1: begin
            busy_c           = 1'b1;
            mr_read_c        = 1'b1;
            enable_c[EN_MDR] = 1'b1;
            if (bus.mem_rdy) state_nx = S_T2;
         end
         S_T2: begin
            busy_c          = 1'b1;
            sel_c           = SEL_MDR;
            enable_c[EN_IR] = 1'b1;
            state_nx        = S_T3;
         end
         S_T3: begin
            busy_c = 1'b1;
            if (legal) begin
               sel_c          = W_SEL'(rb);
               enable_c[EN_Y] = 1'b1;
               state_nx       = S_T4;
            end else begin
               state_nx = S_ILL;
            end
         end
         S_T4: begin
            busy_c         = 1'b1;
            sel_c          = W_SEL'(rc);
            enable_c[EN_Z] = 1'b1;
            alu_c          = alu_op;
            state_nx       = S_T5;
         end
         S_T5: begin
            busy_c   = 1'b1;
            sel_c    = SEL_ZLO;
            enable_c = W_ENABLE'(1) << ra;
            state_nx = bus.run ? S_T0 : S_IDLE;
         end
         S_ILL:   illegal_c = 1'b1;
         default: state_nx  = S_IDLE;
      endcase
   end

   assign bus.enable          = enable_c;
   assign bus.busSelect       = sel_c;
   assign bus.MR_Read         = mr_read_c;
   assign bus.inc_pc          = inc_pc_c;
   assign bus.Control_Signals = alu_c;
   assign bus.busy            = busy_c;
   assign bus.illegal         = illegal_c;
endmodule

// File: tb/tb_dp_control_sequencer.sv
// Directed bench for dp_control_sequencer: expected per-cycle outputs are queued as each
// instruction is issued and popped/compared on every falling edge.
module tb_dp_control_sequencer;
   typedef struct packed {
      logic [31:0] enable;
      logic [4:0]  bsel;
      logic        mr;
      logic        inc;
      logic [3:0]  cs;
      logic        busy;
      logic        ill;
   } outs_t;

   logic clk = 1'b0;
   logic clr;

   dp_ctrl_if #(.W_ENABLE(32)) bus ();

   dp_control_sequencer #(.W_ENABLE(32)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   outs_t exp_q[$];
   string tag_q[$];
   int    errors = 0;
   int    checks = 0;

   function automatic outs_t mk(logic [31:0] en, logic [4:0] bs, logic mr, logic inc,
                                logic [3:0] cs, logic busy, logic ill);
      outs_t o;
      o.enable = en; o.bsel = bs; o.mr = mr; o.inc = inc;
      o.cs = cs; o.busy = busy; o.ill = ill;
      return o;
   endfunction

   function automatic outs_t observe();
      return mk(bus.enable, bus.busSelect, bus.MR_Read, bus.inc_pc,
                bus.Control_Signals, bus.busy, bus.illegal);
   endfunction

   function automatic outs_t o_idle(); return mk(32'h0, 5'd31, 0, 0, 4'd0, 0, 0); endfunction
   function automatic outs_t o_ill();  return mk(32'h0, 5'd31, 0, 0, 4'd0, 0, 1); endfunction

   task automatic push(input string tag, input outs_t e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic check_pop();
      outs_t e, g;
      string t;
      checks++;
      assert (exp_q.size() != 0) else begin
         errors++;
         $error("FAIL scoreboard_empty: got none expected an entry");
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         g = observe();
         assert (g === e) else begin
            errors++;
            $error("FAIL %s: got en=%h bs=%0d mr=%b inc=%b cs=%0d busy=%b ill=%b expected en=%h bs=%0d mr=%b inc=%b cs=%0d busy=%b ill=%b",
                   t, g.enable, g.bsel, g.mr, g.inc, g.cs, g.busy, g.ill,
                   e.enable, e.bsel, e.mr, e.inc, e.cs, e.busy, e.ill);
         end
      end
   endtask

   // Fetch phase expectations; T1 repeats once per wait cycle.
   task automatic push_fetch(input int waits);
      push("T0", mk(32'h02100000, 5'd20, 0, 1, 4'd0, 1, 0));
      for (int i = 0; i <= waits; i++)
         push("T1", mk(32'h00200000, 5'd31, 1, 0, 4'd0, 1, 0));
      push("T2", mk(32'h00800000, 5'd21, 0, 0, 4'd0, 1, 0));
   endtask

   // Execute phase expectations from the instruction word.
   task automatic push_exec(input logic [31:0] iv);
      logic [4:0]  op;
      logic [3:0]  ra, rb, rc;
      logic [3:0]  cs;
      logic        ok;
      logic [31:0] one;
      op = iv[31:27]; ra = iv[26:23]; rb = iv[22:19]; rc = iv[18:15];
      ok = 1'b1;
      case (op)
         5'b00011: cs = 4'd1;
         5'b00100: cs = 4'd2;
         5'b00101: cs = 4'd3;
         5'b00110: cs = 4'd4;
         default: begin cs = 4'd0; ok = 1'b0; end
      endcase
      one = 32'd1;
      if (ok) begin
         push("T3", mk(32'h08000000, {1'b0, rb}, 0, 0, 4'd0, 1, 0));
         push("T4", mk(32'h01000000, {1'b0, rc}, 0, 0, cs, 1, 0));
         push("T5", mk(one << ra, 5'd19, 0, 0, 4'd0, 1, 0));
      end else begin
         push("T3_illegal", mk(32'h0, 5'd31, 0, 0, 4'd0, 1, 0));
      end
   endtask

   // Pop n entries, one per falling edge, driving mem_rdy for the T1 wait and run at T2.
   task automatic drain(input int n, input int waits, input logic run_t2);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check_pop();
         bus.mem_rdy = !(k >= 1 && k <= waits);
         if (k == waits + 2) bus.run = run_t2;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      clr = 1'b1; bus.run = 1'b0; bus.mem_rdy = 1'b1; bus.ir = 32'h0;
      push("reset_hold", o_idle());
      drain(1, 0, 1'b0);
      clr = 1'b0;
      push("idle_run0", o_idle());
      push("idle_run0", o_idle());
      drain(2, 0, 1'b0);

      // Async clear in the middle of T3.
      bus.ir = 32'h20A28000; bus.run = 1'b1;
      push_fetch(0);
      push("T3", mk(32'h08000000, 5'd4, 0, 0, 4'd0, 1, 0));
      drain(4, 0, 1'b1);
      #2 clr = 1'b1; bus.run = 1'b0;
      #1 push("async_clr", o_idle());
      check_pop();
      @(negedge clk);
      clr = 1'b0;
      push("idle_after_clr", o_idle());
      push("idle_after_clr", o_idle());
      drain(2, 0, 1'b0);

      // SUB, ADD, OR back-to-back with run held.
      bus.run = 1'b1;
      bus.ir = 32'h20A28000; push_fetch(0); push_exec(bus.ir); drain(6, 0, 1'b1);
      bus.ir = 32'h19198000; push_fetch(0); push_exec(bus.ir); drain(6, 0, 1'b1);
      bus.ir = 32'h37FF8000; push_fetch(0); push_exec(bus.ir); drain(6, 0, 1'b1);

      // AND with three memory wait cycles, run dropped during T2.
      bus.ir = 32'h2B878000; push_fetch(3); push_exec(bus.ir); drain(9, 3, 1'b0);
      push("idle_after_drop", o_idle());
      push("idle_after_drop", o_idle());
      drain(2, 0, 1'b0);

      // Illegal opcode traps and holds regardless of run.
      bus.ir = 32'hF8000000; bus.run = 1'b1;
      push_fetch(0); push_exec(bus.ir);
      push("ill", o_ill()); push("ill", o_ill()); push("ill", o_ill());
      drain(7, 0, 1'b1);
      bus.run = 1'b0;
      push("ill_run0", o_ill());
      drain(1, 0, 1'b0);
      bus.run = 1'b1;
      push("ill_run1", o_ill());
      drain(1, 0, 1'b1);
      bus.run = 1'b0;
      #2 clr = 1'b1;
      #1 push("ill_clr", o_idle());
      check_pop();
      @(negedge clk);
      clr = 1'b0;
      push("idle_after_ill", o_idle());
      drain(1, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
